hash_grid_idx_gen: RTL

Multi-resolution successor to the single-level hash index calculator in the hash-encoding front end. It accepts one normalised 3-D sample point and walks NUM_LEVELS grid levels. For each level it emits the 8 corner table addresses plus the trilinear fractions. Each level uses dense indexing when the grid fits in TABLE_SIZE and spatial hashing otherwise. Output feeds the embedding-table fetch unit through a valid/ready handshake.

---
 rtl/hash_enc_pkg.sv | 22 ++
 rtl/hash_corner_idx.sv | 36 +++
 rtl/hash_grid_idx_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hash_enc_pkg.sv
// Shared types, defaults and helpers for the multi-resolution hash grid index generator.
package hash_enc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCALE,
      CORNER,
      INDEX,
      OUT
   } state_e;

   localparam logic [31:0] DEF_PRIME1 = 32'h9E3779B1;
   localparam logic [31:0] DEF_PRIME2 = 32'h30025795;

   // Corner number to {z,y,x} offset bits.
   function automatic logic [2:0] corner_offset(input int unsigned c);
      logic [2:0] ofs;
      ofs = 3'(c % 8);
      return ofs;
   endfunction

endpackage

// File: rtl/hash_corner_idx.sv
// Combinational table address for one grid corner: dense linear index or spatial hash,
// reduced to the level table size and prefixed with the level number.
module hash_corner_idx
   import hash_enc_pkg::*;
#(
   parameter int unsigned RES_W      = 12,
   parameter int unsigned LOG2_TABLE = 12,
   parameter int unsigned LVL_W      = 2,
   parameter logic [31:0] PRIME1     = DEF_PRIME1,
   parameter logic [31:0] PRIME2     = DEF_PRIME2
)(
   input  logic [RES_W:0]                  cx_i,
   input  logic [RES_W:0]                  cy_i,
   input  logic [RES_W:0]                  cz_i,
   input  logic [RES_W-1:0]                res_i,
   input  logic                            dense_i,
   input  logic [LVL_W-1:0]                level_i,
   output logic [LOG2_TABLE+LVL_W-1:0]     addr_o
);

   localparam int unsigned RW1 = RES_W + 1;

   logic [RES_W:0]        span;
   logic [LOG2_TABLE-1:0] dense_loc;
   logic [LOG2_TABLE-1:0] hash_loc;

   // Only the low LOG2_TABLE bits survive, so 32-bit wrap in either path is harmless.
   always_comb begin
      span      = RW1'(res_i) + RW1'(1);
      dense_loc = LOG2_TABLE'(32'(cx_i) + 32'(cy_i) * 32'(span)
                              + 32'(cz_i) * 32'(span) * 32'(span));
      hash_loc  = LOG2_TABLE'(32'(cx_i) ^ (32'(cy_i) * PRIME1) ^ (32'(cz_i) * PRIME2));
      addr_o    = {level_i, (dense_i ? dense_loc : hash_loc)};
   end

endmodule

// File: rtl/hash_grid_idx_gen.sv
// Multi-resolution hash grid index generator: walks NUM_LEVELS levels per sample and
// emits 8 corner table addresses plus trilinear fractions per level.
module hash_grid_idx_gen
   import hash_enc_pkg::*;
#(
   parameter int unsigned COORD_W    = 16,
   parameter int unsigned RES_W      = 12,
   parameter int unsigned NUM_LEVELS = 4,
   parameter int unsigned LOG2_TABLE = 12,
   parameter logic [31:0] PRIME1     = DEF_PRIME1,
   parameter logic [31:0] PRIME2     = DEF_PRIME2,
   localparam int unsigned LVL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
   localparam int unsigned AW        = LOG2_TABLE + LVL_W
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [COORD_W-1:0]            in_x,
   input  logic [COORD_W-1:0]            in_y,
   input  logic [COORD_W-1:0]            in_z,
   input  logic [NUM_LEVELS*RES_W-1:0]   level_res,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [8*AW-1:0]               out_idx,
   output logic [3*COORD_W-1:0]          out_frac,
   output logic [LVL_W-1:0]              out_level,
   output logic                          out_last
);

   localparam int unsigned PW  = COORD_W + RES_W;
   localparam int unsigned DW  = 3 * (RES_W + 1);
   localparam int unsigned RW1 = RES_W + 1;

   state_e                        state_q;
   logic [COORD_W-1:0]            coord_q [3];
   logic [NUM_LEVELS*RES_W-1:0]   res_all_q;
   logic [LVL_W-1:0]              level_q;
   logic [RES_W-1:0]              res_q;
   logic                          dense_q;
   logic [RES_W-1:0]              floor_q [3];
   logic [COORD_W-1:0]            frac_q  [3];
   logic [RES_W:0]                lo_q    [3];
   logic [RES_W:0]                hi_q    [3];

   logic                          out_valid_q;
   logic [8*AW-1:0]               out_idx_q;
   logic [3*COORD_W-1:0]          out_frac_q;
   logic [LVL_W-1:0]              out_level_q;
   logic                          out_last_q;

   logic [RES_W-1:0]              res_d;
   logic [DW-1:0]                 span_d;
   logic                          dense_d;
   logic [PW-1:0]                 prod_d  [3];
   logic [RES_W-1:0]              floor_d [3];
   logic [COORD_W-1:0]            frac_d  [3];
   logic [8*AW-1:0]               idx_d;
   logic                          last_lvl;

   assign last_lvl = (level_q == LVL_W'(NUM_LEVELS - 1));

   // Density test is done at full width so (res+1)^3 never wraps.
   always_comb begin
      res_d   = res_all_q[level_q*RES_W +: RES_W];
      span_d  = DW'(res_d) + DW'(1);
      dense_d = (span_d * span_d * span_d) <= (DW'(1) << LOG2_TABLE);
      for (int unsigned i = 0; i < 3; i++) begin
         prod_d[i]  = PW'(coord_q[i]) * PW'(res_d);
         floor_d[i] = prod_d[i][PW-1 -: RES_W];
         frac_d[i]  = prod_d[i][COORD_W-1:0];
      end
   end

   for (genvar c = 0; c < 8; c++) begin : g_corner
      localparam logic [2:0] OFS = corner_offset(c);
      hash_corner_idx #(
         .RES_W      (RES_W),
         .LOG2_TABLE (LOG2_TABLE),
         .LVL_W      (LVL_W),
         .PRIME1     (PRIME1),
         .PRIME2     (PRIME2)
      ) u_idx (
         .cx_i    (OFS[0] ? hi_q[0] : lo_q[0]),
         .cy_i    (OFS[1] ? hi_q[1] : lo_q[1]),
         .cz_i    (OFS[2] ? hi_q[2] : lo_q[2]),
         .res_i   (res_q),
         .dense_i (dense_q),
         .level_i (level_q),
         .addr_o  (idx_d[c*AW +: AW])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         coord_q     <= '{default: '0};
         res_all_q   <= '0;
         level_q     <= '0;
         res_q       <= '0;
         dense_q     <= 1'b0;
         floor_q     <= '{default: '0};
         frac_q      <= '{default: '0};
         lo_q        <= '{default: '0};
         hi_q        <= '{default: '0};
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_frac_q  <= '0;
         out_level_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  coord_q[0] <= in_x;
                  coord_q[1] <= in_y;
                  coord_q[2] <= in_z;
                  res_all_q  <= level_res;
                  level_q    <= '0;
                  state_q    <= SCALE;
               end
            end
            SCALE: begin
               res_q   <= res_d;
               dense_q <= dense_d;
               floor_q <= floor_d;
               frac_q  <= frac_d;
               state_q <= CORNER;
            end
            CORNER: begin
               for (int unsigned i = 0; i < 3; i++) begin
                  lo_q[i] <= RW1'(floor_q[i]);
                  hi_q[i] <= RW1'(floor_q[i]) + RW1'(1);
               end
               state_q <= INDEX;
            end
            INDEX: begin
               out_idx_q   <= idx_d;
               out_frac_q  <= {frac_q[2], frac_q[1], frac_q[0]};
               out_level_q <= level_q;
               out_last_q  <= last_lvl;
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (last_lvl) begin
                     state_q <= IDLE;
                  end else begin
                     level_q <= level_q + LVL_W'(1);
                     state_q <= SCALE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_frac  = out_frac_q;
   assign out_level = out_level_q;
   assign out_last  = out_last_q;

endmodule
